// File: rtl/vm_dispense_tray.sv
// vm_dispense_tray: customer-side tray that accepts products, models a
// mechanical dispense delay and totals the change returned per transaction.
// Optional build macro: VM_TRAY_BACKPRESSURE_EN adds i_tray_full, which stalls
// acceptance and the dispense countdown while it is high.
module vm_dispense_tray #(
    parameter int DISPENSE_CYCLES = 4,
    parameter int CHANGE_TIMEOUT  = 16,
    parameter int ACC_W           = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_product_code,
    input  logic             i_product_valid,
    output logic             o_product_ready,
    input  logic [3:0]       i_change_denomination_code,
    input  logic             i_change_valid,
    input  logic             i_no_change,
`ifdef VM_TRAY_BACKPRESSURE_EN
    input  logic             i_tray_full,
`endif
    output logic [2:0]       o_dispensed_code,
    output logic             o_dispensed_strobe,
    output logic [ACC_W-1:0] o_change_total,
    output logic [7:0]       o_coin_count,
    output logic             o_txn_done,
    output logic             o_txn_no_change,
    output logic             o_err_bad_code
);

    localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam int IW = $clog2(CHANGE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        COLLECT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Denomination code to value in cents; code 15 is not a valid coin.
    function automatic logic [15:0] code_to_cents(input logic [3:0] code);
        case (code)
            4'd0:    code_to_cents = 16'd50000;
            4'd1:    code_to_cents = 16'd20000;
            4'd2:    code_to_cents = 16'd10000;
            4'd3:    code_to_cents = 16'd5000;
            4'd4:    code_to_cents = 16'd2000;
            4'd5:    code_to_cents = 16'd1000;
            4'd6:    code_to_cents = 16'd500;
            4'd7:    code_to_cents = 16'd200;
            4'd8:    code_to_cents = 16'd100;
            4'd9:    code_to_cents = 16'd50;
            4'd10:   code_to_cents = 16'd25;
            4'd11:   code_to_cents = 16'd10;
            4'd12:   code_to_cents = 16'd5;
            4'd13:   code_to_cents = 16'd2;
            4'd14:   code_to_cents = 16'd1;
            default: code_to_cents = 16'd0;
        endcase
    endfunction

    // Saturating add of a coin value onto the accumulator.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [15:0]      b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W-15){1'b0}}, b};
        if (sum[ACC_W]) begin
            sat_add = {ACC_W{1'b1}};
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction

    logic             tray_full_s;
    state_t           state_r, state_nxt_s;
    logic [DW-1:0]    dcnt_r, dcnt_nxt_s;
    logic [IW-1:0]    idle_r, idle_nxt_s;
    logic [2:0]       code_r;
    logic             accept_s, strobe_nxt_s;
    logic [ACC_W-1:0] acc_r, acc_base_s, acc_nxt_s;
    logic [7:0]       cnt_r, cnt_base_s, cnt_nxt_s;
    logic             nc_r, nc_nxt_s;
    logic             coin_ok_s, bad_code_s;
    logic             ready_r, strobe_r, txn_done_r, txn_nc_r, err_r;
    logic [2:0]       disp_code_r;
    logic [ACC_W-1:0] total_r;
    logic [7:0]       coins_r;

`ifdef VM_TRAY_BACKPRESSURE_EN
    assign tray_full_s = i_tray_full;
`else
    assign tray_full_s = 1'b0;
`endif

    // Next-state logic for the transaction FSM and its two counters.
    always_comb begin
        state_nxt_s  = state_r;
        dcnt_nxt_s   = dcnt_r;
        idle_nxt_s   = idle_r;
        accept_s     = 1'b0;
        strobe_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_product_valid && ready_r) begin
                    accept_s     = 1'b1;
                    state_nxt_s  = DISPENSE;
                    dcnt_nxt_s   = DW'(DISPENSE_CYCLES - 1);
                    strobe_nxt_s = (DISPENSE_CYCLES == 1);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DISPENSE: begin
                // The strobe is registered, so it is raised one cycle ahead
                // of the final countdown cycle.
                if (dcnt_r == {DW{1'b0}}) begin
                    state_nxt_s = COLLECT;
                    idle_nxt_s  = {IW{1'b0}};
                end else if (!tray_full_s) begin
                    dcnt_nxt_s   = dcnt_r - DW'(1);
                    strobe_nxt_s = (dcnt_r == DW'(1));
                end else begin
                    dcnt_nxt_s = dcnt_r;
                end
            end
            COLLECT: begin
                if (i_no_change ||
                    (!i_change_valid && (idle_r == IW'(CHANGE_TIMEOUT - 1)))) begin
                    state_nxt_s = DONE;
                end else if (i_change_valid) begin
                    idle_nxt_s = {IW{1'b0}};
                end else begin
                    idle_nxt_s = idle_r + IW'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Live change accumulation; the DONE cycle restarts from zero so any
    // event seen then belongs to the next transaction.
    always_comb begin
        coin_ok_s  = i_change_valid && (i_change_denomination_code != 4'd15);
        bad_code_s = i_change_valid && (i_change_denomination_code == 4'd15);
        if (state_r == DONE) begin
            acc_base_s = {ACC_W{1'b0}};
            cnt_base_s = 8'd0;
            nc_nxt_s   = i_no_change;
        end else begin
            acc_base_s = acc_r;
            cnt_base_s = cnt_r;
            nc_nxt_s   = nc_r | i_no_change;
        end
        if (coin_ok_s) begin
            acc_nxt_s = sat_add(acc_base_s, code_to_cents(i_change_denomination_code));
            cnt_nxt_s = (cnt_base_s == 8'hFF) ? cnt_base_s : (cnt_base_s + 8'd1);
        end else begin
            acc_nxt_s = acc_base_s;
            cnt_nxt_s = cnt_base_s;
        end
    end

    // State, counters, live accumulators and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            dcnt_r      <= {DW{1'b0}};
            idle_r      <= {IW{1'b0}};
            code_r      <= 3'd0;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 8'd0;
            nc_r        <= 1'b0;
            ready_r     <= 1'b1;
            strobe_r    <= 1'b0;
            disp_code_r <= 3'd0;
            txn_done_r  <= 1'b0;
            total_r     <= {ACC_W{1'b0}};
            coins_r     <= 8'd0;
            txn_nc_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dcnt_r     <= dcnt_nxt_s;
            idle_r     <= idle_nxt_s;
            acc_r      <= acc_nxt_s;
            cnt_r      <= cnt_nxt_s;
            nc_r       <= nc_nxt_s;
            ready_r    <= (state_nxt_s == IDLE) && !tray_full_s;
            strobe_r   <= strobe_nxt_s;
            txn_done_r <= (state_nxt_s == DONE);
            err_r      <= bad_code_s;
            if (accept_s) begin
                code_r <= i_product_code;
            end
            if (strobe_nxt_s) begin
                disp_code_r <= accept_s ? i_product_code : code_r;
            end
            if (state_nxt_s == DONE) begin
                total_r  <= acc_nxt_s;
                coins_r  <= cnt_nxt_s;
                txn_nc_r <= nc_nxt_s;
            end
        end
    end

    assign o_product_ready    = ready_r;
    assign o_dispensed_strobe = strobe_r;
    assign o_dispensed_code   = disp_code_r;
    assign o_txn_done         = txn_done_r;
    assign o_change_total     = total_r;
    assign o_coin_count       = coins_r;
    assign o_txn_no_change    = txn_nc_r;
    assign o_err_bad_code     = err_r;

endmodule

// File: tb/tb_vm_dispense_tray.sv
// Directed testbench for vm_dispense_tray with hand-computed expectations.
module tb_vm_dispense_tray;

    logic        i_clk;
    logic        i_rst;
    logic [2:0]  i_product_code;
    logic        i_product_valid;
    logic        o_product_ready;
    logic [3:0]  i_change_denomination_code;
    logic        i_change_valid;
    logic        i_no_change;
    logic [2:0]  o_dispensed_code;
    logic        o_dispensed_strobe;
    logic [19:0] o_change_total;
    logic [7:0]  o_coin_count;
    logic        o_txn_done;
    logic        o_txn_no_change;
    logic        o_err_bad_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    vm_dispense_tray #(
        .DISPENSE_CYCLES(4),
        .CHANGE_TIMEOUT (16),
        .ACC_W          (20)
    ) dut (
        .i_clk                      (i_clk),
        .i_rst                      (i_rst),
        .i_product_code             (i_product_code),
        .i_product_valid            (i_product_valid),
        .o_product_ready            (o_product_ready),
        .i_change_denomination_code (i_change_denomination_code),
        .i_change_valid             (i_change_valid),
        .i_no_change                (i_no_change),
`ifdef VM_TRAY_BACKPRESSURE_EN
        .i_tray_full                (1'b0),
`endif
        .o_dispensed_code           (o_dispensed_code),
        .o_dispensed_strobe         (o_dispensed_strobe),
        .o_change_total             (o_change_total),
        .o_coin_count               (o_coin_count),
        .o_txn_done                 (o_txn_done),
        .o_txn_no_change            (o_txn_no_change),
        .o_err_bad_code             (o_err_bad_code)
    );

    // Free-running 10-unit clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [3:0] code);
        i_change_valid = 1'b1;
        i_change_denomination_code = code;
        tick();
        i_change_valid = 1'b0;
    endtask

    task automatic product(input logic [2:0] code);
        chk("ready_before_product", {31'd0, o_product_ready}, 32'd1);
        i_product_valid = 1'b1;
        i_product_code  = code;
        tick();
        i_product_valid = 1'b0;
    endtask

    // Bounded wait for o_txn_done; returns the number of edges waited.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!o_txn_done && cycles < limit) begin
            tick();
            cycles++;
        end
        chk("txn_done_within_bound", {31'd0, o_txn_done}, 32'd1);
    endtask

    // Directed stimulus sequence.
    initial begin
        i_rst = 1'b1;
        i_product_code = 3'd0;
        i_product_valid = 1'b0;
        i_change_denomination_code = 4'd0;
        i_change_valid = 1'b0;
        i_no_change = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        chk("rst_ready",     {31'd0, o_product_ready},    32'd1);
        chk("rst_strobe",    {31'd0, o_dispensed_strobe}, 32'd0);
        chk("rst_code",      {29'd0, o_dispensed_code},   32'd0);
        chk("rst_total",     {12'd0, o_change_total},     32'd0);
        chk("rst_count",     {24'd0, o_coin_count},       32'd0);
        chk("rst_done",      {31'd0, o_txn_done},         32'd0);
        chk("rst_nochange",  {31'd0, o_txn_no_change},    32'd0);
        chk("rst_err",       {31'd0, o_err_bad_code},     32'd0);

        // Product 3: strobe in the fourth dispense cycle, timeout closes txn.
        product(3'd3);
        chk("t1_ready_low",  {31'd0, o_product_ready},    32'd0);
        chk("t1_strobe_c1",  {31'd0, o_dispensed_strobe}, 32'd0);
        tick();
        chk("t1_strobe_c2",  {31'd0, o_dispensed_strobe}, 32'd0);
        tick();
        chk("t1_strobe_c3",  {31'd0, o_dispensed_strobe}, 32'd0);
        tick();
        chk("t1_strobe_c4",  {31'd0, o_dispensed_strobe}, 32'd1);
        chk("t1_disp_code",  {29'd0, o_dispensed_code},   32'd3);
        wait_done(64, cyc);
        chk("t1_done_latency", cyc, 32'd17);
        chk("t1_total",      {12'd0, o_change_total},     32'd0);
        chk("t1_count",      {24'd0, o_coin_count},       32'd0);
        chk("t1_ready_done", {31'd0, o_product_ready},    32'd0);
        tick();
        chk("t1_done_pulse", {31'd0, o_txn_done},         32'd0);
        chk("t1_ready_back", {31'd0, o_product_ready},    32'd1);

        // Product 5 with coins 2, 8, 10 back-to-back.
        product(3'd5);
        coin(4'd2);
        coin(4'd8);
        coin(4'd10);
        chk("t2_strobe",     {31'd0, o_dispensed_strobe}, 32'd1);
        chk("t2_disp_code",  {29'd0, o_dispensed_code},   32'd5);
        wait_done(64, cyc);
        chk("t2_total",      {12'd0, o_change_total},     32'd10125);
        chk("t2_count",      {24'd0, o_coin_count},       32'd3);
        chk("t2_nochange",   {31'd0, o_txn_no_change},    32'd0);
        tick();

        // Change before the product counts toward that product's txn.
        coin(4'd0);
        coin(4'd0);
        coin(4'd0);
        chk("t3_total_held", {12'd0, o_change_total},     32'd10125);
        product(3'd1);
        wait_done(64, cyc);
        chk("t3_total",      {12'd0, o_change_total},     32'd150000);
        chk("t3_count",      {24'd0, o_coin_count},       32'd3);
        tick();

        // No-change closes the txn on the next edge.
        product(3'd2);
        tick();
        tick();
        tick();
        tick();
        i_no_change = 1'b1;
        tick();
        i_no_change = 1'b0;
        chk("t4_done",       {31'd0, o_txn_done},         32'd1);
        chk("t4_total",      {12'd0, o_change_total},     32'd0);
        chk("t4_count",      {24'd0, o_coin_count},       32'd0);
        chk("t4_nochange",   {31'd0, o_txn_no_change},    32'd1);
        tick();
        chk("t4_done_pulse", {31'd0, o_txn_done},         32'd0);
        chk("t4_nc_held",    {31'd0, o_txn_no_change},    32'd1);

        // Bad code 15 flagged once and ignored; code 14 adds one cent.
        coin(4'd15);
        chk("t5_err_pulse",  {31'd0, o_err_bad_code},     32'd1);
        coin(4'd14);
        chk("t5_err_clear",  {31'd0, o_err_bad_code},     32'd0);
        product(3'd1);
        wait_done(64, cyc);
        chk("t5_total",      {12'd0, o_change_total},     32'd1);
        chk("t5_count",      {24'd0, o_coin_count},       32'd1);
        chk("t5_nochange",   {31'd0, o_txn_no_change},    32'd0);

        // A coin in the DONE cycle belongs to the next txn.
        coin(4'd12);
        chk("t6_snap_excl",  {12'd0, o_change_total},     32'd1);
        product(3'd4);
        wait_done(64, cyc);
        chk("t6_total",      {12'd0, o_change_total},     32'd5);
        chk("t6_count",      {24'd0, o_coin_count},       32'd1);
        tick();

        // 21 coins of 50000 saturate a 20-bit accumulator.
        for (int i = 0; i < 21; i++) begin
            coin(4'd0);
        end
        product(3'd7);
        wait_done(64, cyc);
        chk("t7_total_sat",  {12'd0, o_change_total},     32'd1048575);
        chk("t7_count",      {24'd0, o_coin_count},       32'd21);
        tick();

        // Reset during dispense abandons the txn.
        product(3'd6);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t8_ready",      {31'd0, o_product_ready},    32'd1);
        chk("t8_strobe",     {31'd0, o_dispensed_strobe}, 32'd0);
        chk("t8_done",       {31'd0, o_txn_done},         32'd0);
        chk("t8_total",      {12'd0, o_change_total},     32'd0);
        chk("t8_count",      {24'd0, o_coin_count},       32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t8_no_strobe", {31'd0, o_dispensed_strobe}, 32'd0);
            chk("t8_no_done",   {31'd0, o_txn_done},         32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
